// File: rtl/decode38_hold.sv
// decode38_hold
// Registered 3-to-8 decoder with a programmable one-hot hold time.
// An event (in_valid & in_ready) is decoded into a one-hot line that stays
// high for HOLD_CYCLES cycles. During that time no new event is taken.
// The block also keeps a sticky mask of every code seen and a saturating
// count of accepted events.
//
// Ports:
//   clk        rising-edge system clock
//   rst        synchronous, active-high reset (highest priority)
//   in_valid   upstream event present; must be held until accepted
//   in_code    3-bit index to decode
//   in_ready   high in IDLE when rst is low (combinational)
//   clr        synchronous clear of sticky mask and event count
//   onehot     1 << code while holding, else 0
//   sticky     OR of accepted one-hot values since last rst/clr
//   last_code  code of the most recent accepted event
//   ev_cnt     accepted-event count, saturates at 255
//   busy       high while in HOLD
//   ledr       {sticky, onehot}
module decode38_hold #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [2:0]  in_code,
  output logic        in_ready,
  input  logic        clr,
  output logic [7:0]  onehot,
  output logic [7:0]  sticky,
  output logic [2:0]  last_code,
  output logic [7:0]  ev_cnt,
  output logic        busy,
  output logic [15:0] ledr
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // The down-counter starts at HOLD_CYCLES-1 and the exit happens on the
  // edge where it reads zero, giving exactly HOLD_CYCLES cycles of onehot.
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

  function automatic logic [7:0] dec3(input logic [2:0] code);
    dec3 = 8'b0000_0001 << code;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [7:0]  onehot_q, onehot_d;
  logic [7:0]  sticky_q, sticky_d;
  logic [2:0]  last_code_q, last_code_d;
  logic [7:0]  ev_cnt_q, ev_cnt_d;
  logic        in_ready_s;
  logic        accept_s;
  logic [7:0]  code_dec_s;

  assign in_ready_s = (state_q == ST_IDLE) & ~rst;
  assign accept_s   = in_valid & in_ready_s;
  assign code_dec_s = dec3(in_code);

  // Next-state logic for the hold FSM and the event bookkeeping registers.
  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    onehot_d    = onehot_q;
    last_code_d = last_code_q;
    sticky_d    = sticky_q;
    ev_cnt_d    = ev_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d     = ST_HOLD;
          onehot_d    = code_dec_s;
          last_code_d = in_code;
          hcnt_d      = HOLD_INIT;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hcnt_q == 8'd0) begin
          state_d  = ST_IDLE;
          onehot_d = 8'h00;
        end else begin
          hcnt_d   = hcnt_q - 8'd1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        onehot_d = 8'h00;
        hcnt_d   = 8'd0;
      end
    endcase

    // A clear in the same cycle as an accept still records the new event.
    if (clr && accept_s) begin
      sticky_d = code_dec_s;
      ev_cnt_d = 8'd1;
    end else if (clr) begin
      sticky_d = 8'h00;
      ev_cnt_d = 8'd0;
    end else if (accept_s) begin
      sticky_d = sticky_q | code_dec_s;
      ev_cnt_d = (ev_cnt_q == 8'hFF) ? 8'hFF : (ev_cnt_q + 8'd1);
    end else begin
      sticky_d = sticky_q;
      ev_cnt_d = ev_cnt_q;
    end
  end

  // State registers with synchronous reset taking priority over all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hcnt_q      <= 8'd0;
      onehot_q    <= 8'h00;
      sticky_q    <= 8'h00;
      last_code_q <= 3'd0;
      ev_cnt_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      onehot_q    <= onehot_d;
      sticky_q    <= sticky_d;
      last_code_q <= last_code_d;
      ev_cnt_q    <= ev_cnt_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign onehot    = onehot_q;
  assign sticky    = sticky_q;
  assign last_code = last_code_q;
  assign ev_cnt    = ev_cnt_q;
  assign busy      = (state_q == ST_HOLD);
  assign ledr      = {sticky_q, onehot_q};

endmodule
